// File: rtl/core_pkg.sv
// Shared encodings for the multi-cycle core sequencer: FSM states, opcode
// classes, RV32I base opcodes and the datapath mux select codes.
package core_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JAL    = 3'd4,
        CLS_JALR   = 3'd5
    } op_class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_REL   = 2'b01;
    localparam logic [1:0] PC_RS1   = 2'b10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode decode table: maps the IR opcode field to an
// instruction class and the static datapath controls for that class.
module seq_decode
    import core_pkg::*;
(
    input  logic [31:0] i_ir,
    output logic [2:0]  o_class,
    output logic [2:0]  o_imm_sel,
    output logic [1:0]  o_wb_sel,
    output logic        o_alu_src_imm,
    output logic [1:0]  o_alu_op,
    output logic        o_illegal
);

    logic [6:0] w_opcode;
    logic       w_unused_ir;

    assign w_opcode    = i_ir[6:0];
    assign w_unused_ir = ^i_ir[31:7];

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        o_class       = CLS_ALU;
        o_imm_sel     = IMM_I;
        o_wb_sel      = WB_ALU;
        o_alu_src_imm = 1'b1;
        o_alu_op      = ALU_ADD;
        o_illegal     = 1'b0;
        case (w_opcode)
            OP_R: begin
                o_alu_src_imm = 1'b0;
                o_alu_op      = ALU_FUNCT;
            end
            OP_I_ALU: o_alu_op = ALU_FUNCT;
            OP_LOAD: begin
                o_class  = CLS_LOAD;
                o_wb_sel = WB_MEM;
            end
            OP_STORE: begin
                o_class   = CLS_STORE;
                o_imm_sel = IMM_S;
            end
            OP_BRANCH: begin
                o_class       = CLS_BRANCH;
                o_imm_sel     = IMM_B;
                o_alu_src_imm = 1'b0;
                o_alu_op      = ALU_SUB;
            end
            OP_JAL: begin
                o_class   = CLS_JAL;
                o_imm_sel = IMM_J;
                o_wb_sel  = WB_PC4;
            end
            OP_JALR: begin
                o_class  = CLS_JALR;
                o_wb_sel = WB_PC4;
            end
            OP_LUI: begin
                o_imm_sel = IMM_U;
                o_wb_sel  = WB_IMM;
            end
            OP_AUIPC: o_imm_sel = IMM_U;
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with bounded
// memory handshakes and a sticky TRAP state left only through reset.
module core_seq_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        br_taken,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [2:0]  imm_sel,
    output logic        alu_src_imm,
    output logic [1:0]  alu_op,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [31:0] retired,
    output logic [2:0]  state
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_ir;
    logic [7:0]  r_wait;
    logic [31:0] r_retired;
    logic        r_illegal;
    logic        r_imem_req;
    logic        r_dmem_req;
    logic        r_dmem_we;

    logic [2:0]  w_class;
    logic [2:0]  w_imm_sel;
    logic [1:0]  w_wb_sel;
    logic        w_alu_src_imm;
    logic [1:0]  w_alu_op;
    logic        w_dec_illegal;
    logic        w_active;
    logic        w_fetch_ack;
    logic        w_mem_ack;
    logic        w_is_branch;
    logic        w_pc_we;

    seq_decode u_decode (
        .i_ir          (r_ir),
        .o_class       (w_class),
        .o_imm_sel     (w_imm_sel),
        .o_wb_sel      (w_wb_sel),
        .o_alu_src_imm (w_alu_src_imm),
        .o_alu_op      (w_alu_op),
        .o_illegal     (w_dec_illegal)
    );

    // Acks only count while the matching request is actually raised.
    assign w_fetch_ack = (r_state == ST_FETCH) && r_imem_req && imem_ack;
    assign w_mem_ack   = (r_state == ST_MEM) && r_dmem_req && dmem_ack;
    assign w_is_branch = (w_class == CLS_BRANCH);
    assign w_active    = (r_state == ST_DECODE) || (r_state == ST_EXEC) ||
                         (r_state == ST_MEM) || (r_state == ST_WB);

    assign w_pc_we = ((r_state == ST_EXEC) && w_is_branch) ||
                     (w_mem_ack && (w_class == CLS_STORE)) ||
                     (r_state == ST_WB);

    always_comb begin
        pc_sel = PC_PLUS4;
        if ((r_state == ST_EXEC) && w_is_branch && br_taken) pc_sel = PC_REL;
        if ((r_state == ST_WB) && (w_class == CLS_JAL))      pc_sel = PC_REL;
        if ((r_state == ST_WB) && (w_class == CLS_JALR))     pc_sel = PC_RS1;
    end

    assign ir_we       = w_fetch_ack;
    assign pc_we       = w_pc_we;
    assign rf_we       = (r_state == ST_WB);
    assign imm_sel     = w_active ? w_imm_sel : IMM_I;
    assign wb_sel      = w_active ? w_wb_sel : WB_ALU;
    assign alu_src_imm = w_active ? w_alu_src_imm : 1'b0;
    assign alu_op      = w_active ? w_alu_op : ALU_ADD;
    assign imem_req    = r_imem_req;
    assign dmem_req    = r_dmem_req;
    assign dmem_we     = r_dmem_we;
    assign illegal     = r_illegal;
    assign retired     = r_retired;
    assign state       = r_state;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_FETCH;
            r_ir       <= '0;
            r_wait     <= '0;
            r_retired  <= '0;
            r_illegal  <= 1'b0;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
        end else begin
            if (w_pc_we) r_retired <= r_retired + 32'd1;
            case (r_state)
                ST_FETCH: begin
                    if (!r_imem_req) begin
                        r_imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        r_ir       <= instr;
                        r_imem_req <= 1'b0;
                        r_wait     <= '0;
                        r_state    <= ST_DECODE;
                    end else if (r_wait == WAIT_LAST) begin
                        r_imem_req <= 1'b0;
                        r_wait     <= '0;
                        r_illegal  <= 1'b1;
                        r_state    <= ST_TRAP;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                ST_DECODE: begin
                    if (w_dec_illegal) begin
                        r_illegal <= 1'b1;
                        r_state   <= ST_TRAP;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if ((w_class == CLS_LOAD) || (w_class == CLS_STORE)) begin
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= (w_class == CLS_STORE);
                        r_state    <= ST_MEM;
                    end else if (w_is_branch) begin
                        r_imem_req <= 1'b1;
                        r_state    <= ST_FETCH;
                    end else begin
                        r_state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_wait     <= '0;
                        if (w_class == CLS_STORE) begin
                            r_imem_req <= 1'b1;
                            r_state    <= ST_FETCH;
                        end else begin
                            r_state <= ST_WB;
                        end
                    end else if (r_wait == WAIT_LAST) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_wait     <= '0;
                        r_illegal  <= 1'b1;
                        r_state    <= ST_TRAP;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                ST_WB: begin
                    r_imem_req <= 1'b1;
                    r_state    <= ST_FETCH;
                end
                ST_TRAP: r_state <= ST_TRAP;
                default: begin
                    r_illegal <= 1'b1;
                    r_state   <= ST_TRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench for core_seq_ctrl: builds the expected state trace of each
// instruction from its opcode class and handshake delays, then checks every cycle.
module tb_core_seq_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        br_taken = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_src_imm, rf_we, illegal;
    logic [1:0]  pc_sel, alu_op, wb_sel;
    logic [2:0]  imm_sel, state;
    logic [31:0] retired;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_ret = '0;

    typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC, K_BAD} kind_t;
    typedef struct { int st; logic iack; logic dack; } step_t;

    core_seq_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .br_taken(br_taken), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .imm_sel(imm_sel), .alu_src_imm(alu_src_imm), .alu_op(alu_op),
        .rf_we(rf_we), .wb_sel(wb_sel), .illegal(illegal),
        .retired(retired), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic kind_t kind_of(input logic [6:0] op);
        case (op)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            default:    return K_BAD;
        endcase
    endfunction

    function automatic logic [31:0] imm_of(input kind_t k);
        case (k)
            K_ST:            return 32'd1;
            K_BR:            return 32'd2;
            K_LUI, K_AUIPC:  return 32'd3;
            K_JAL:           return 32'd4;
            default:         return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] wb_of(input kind_t k);
        case (k)
            K_LD:         return 32'd1;
            K_JAL, K_JALR: return 32'd2;
            K_LUI:        return 32'd3;
            default:      return 32'd0;
        endcase
    endfunction

    function automatic step_t mk(input int st, input logic ia, input logic da);
        step_t s;
        s.st = st; s.iack = ia; s.dack = da;
        return s;
    endfunction

    // Reset, then one cycle for the fetch request to come up.
    task automatic do_reset(input string tag);
        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(negedge clk); #1;
        check({tag, " rst state"}, 32'(state), 32'd0);
        check({tag, " rst imem_req"}, 32'(imem_req), 32'd0);
        check({tag, " rst dmem_req"}, 32'(dmem_req), 32'd0);
        check({tag, " rst pc_we"}, 32'(pc_we), 32'd0);
        check({tag, " rst retired"}, retired, 32'd0);
        check({tag, " rst illegal"}, 32'(illegal), 32'd0);
        exp_ret = '0;
        rst_n = 1'b1;
        @(negedge clk); #1;
        check({tag, " post-rst imem_req"}, 32'(imem_req), 32'd1);
        check({tag, " post-rst state"}, 32'(state), 32'd0);
    endtask

    task automatic trap_hold(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            instr    = $urandom();
            #1;
            check({tag, " trap state"}, 32'(state), 32'd5);
            check({tag, " trap illegal"}, 32'(illegal), 32'd1);
            check({tag, " trap imem_req"}, 32'(imem_req), 32'd0);
            check({tag, " trap dmem_req"}, 32'(dmem_req), 32'd0);
            check({tag, " trap strobes"}, {29'd0, ir_we, pc_we, rf_we}, 32'd0);
            check({tag, " trap retired"}, retired, exp_ret);
            @(negedge clk);
        end
    endtask

    // di/dd: extra wait cycles before imem_ack/dmem_ack; rst_at: trace index at which reset is asserted.
    task automatic run(input string tag, input logic [31:0] ins, input int di, input int dd,
                       input logic br, input int rst_at);
        kind_t       k;
        step_t       tr[$];
        step_t       s;
        bit          trap;
        logic        e_pcwe;
        logic [1:0]  e_pcsel;
        k    = kind_of(ins[6:0]);
        trap = 0;
        for (int i = 0; i < ((di < TO) ? di + 1 : TO); i++) tr.push_back(mk(0, (i == di), 1'b0));
        if (di >= TO) begin
            trap = 1;
        end else begin
            tr.push_back(mk(1, 1'b0, 1'b0));
            if (k == K_BAD) begin
                trap = 1;
            end else begin
                tr.push_back(mk(2, 1'b0, 1'b0));
                if (k == K_LD || k == K_ST) begin
                    for (int i = 0; i < ((dd < TO) ? dd + 1 : TO); i++) tr.push_back(mk(3, 1'b0, (i == dd)));
                    if (dd >= TO) trap = 1;
                    else if (k == K_LD) tr.push_back(mk(4, 1'b0, 1'b0));
                end else if (k != K_BR) begin
                    tr.push_back(mk(4, 1'b0, 1'b0));
                end
            end
        end
        for (int i = 0; i < tr.size(); i++) begin
            s = tr[i];
            if (i == rst_at) begin
                dmem_ack = 1'b0; imem_ack = 1'b0; #1;
                check({tag, " state at reset"}, 32'(state), 32'(s.st));
                do_reset({tag, " mid"});
                return;
            end
            instr    = s.iack ? ins : $urandom();
            imem_ack = s.iack | ((s.st != 0) & 1'($urandom_range(0, 1)));
            dmem_ack = s.dack | ((s.st != 3) & 1'($urandom_range(0, 1)));
            br_taken = (s.st == 2) ? br : 1'($urandom_range(0, 1));
            #1;
            e_pcwe  = (s.st == 2 && k == K_BR) || (s.st == 3 && k == K_ST && s.dack) || (s.st == 4);
            e_pcsel = 2'b00;
            if (s.st == 2 && k == K_BR && br) e_pcsel = 2'b01;
            if (s.st == 4 && k == K_JAL)      e_pcsel = 2'b01;
            if (s.st == 4 && k == K_JALR)     e_pcsel = 2'b10;
            check($sformatf("%s[%0d] state", tag, i), 32'(state), 32'(s.st));
            check($sformatf("%s[%0d] imem_req", tag, i), 32'(imem_req), 32'(s.st == 0));
            check($sformatf("%s[%0d] ir_we", tag, i), 32'(ir_we), 32'(s.iack));
            check($sformatf("%s[%0d] dmem_req", tag, i), 32'(dmem_req), 32'(s.st == 3));
            check($sformatf("%s[%0d] dmem_we", tag, i), 32'(dmem_we), 32'(s.st == 3 && k == K_ST));
            check($sformatf("%s[%0d] pc_we", tag, i), 32'(pc_we), 32'(e_pcwe));
            check($sformatf("%s[%0d] pc_sel", tag, i), 32'(pc_sel), 32'(e_pcsel));
            check($sformatf("%s[%0d] rf_we", tag, i), 32'(rf_we), 32'(s.st == 4));
            check($sformatf("%s[%0d] illegal", tag, i), 32'(illegal), 32'd0);
            check($sformatf("%s[%0d] retired", tag, i), retired, exp_ret);
            if (s.st >= 1 && s.st <= 4) begin
                check($sformatf("%s[%0d] imm_sel", tag, i), 32'(imm_sel), imm_of(k));
                check($sformatf("%s[%0d] wb_sel", tag, i), 32'(wb_sel), wb_of(k));
                check($sformatf("%s[%0d] alu_op", tag, i), 32'(alu_op),
                      (k == K_R || k == K_I) ? 32'd2 : (k == K_BR) ? 32'd1 : 32'd0);
                check($sformatf("%s[%0d] alu_src_imm", tag, i), 32'(alu_src_imm),
                      32'(!(k == K_R || k == K_BR)));
            end
            if (e_pcwe) exp_ret = exp_ret + 32'd1;
            @(negedge clk);
        end
        if (trap) trap_hold(tag, 6);
    endtask

    initial begin
        logic [6:0]  ops [9];
        logic [31:0] ins;
        logic [31:0] ret_before;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

        @(negedge clk);
        do_reset("init");

        run("addi", 32'h00500093, 0, 0, 1'b0, -1);
        check("addi retired", retired, 32'd1);

        run("lw", 32'h00002083, 1, 3, 1'b0, -1);

        ret_before = exp_ret;
        run("beq_t", 32'h00000063, 0, 0, 1'b1, -1);
        run("beq_nt", 32'h00000063, 2, 0, 1'b0, -1);
        check("beq retired+2", retired, ret_before + 32'd2);

        run("jal", 32'h0000006F, 0, 0, 1'b0, -1);
        run("jalr", 32'h00008067, 1, 0, 1'b0, -1);
        run("lui", 32'h000000B7, 0, 0, 1'b0, -1);
        run("auipc", 32'h00000097, 0, 0, 1'b0, -1);
        run("sw", 32'h00102023, 0, 2, 1'b0, -1);
        run("add", 32'h002081B3, 3, 0, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            ins = ($urandom() & 32'hFFFF_FF80) | {25'd0, ops[$urandom_range(0, 8)]};
            run($sformatf("rnd%0d", n), ins, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), -1);
        end

        run("bad_op", 32'hFFFF_FFFF, 0, 0, 1'b0, -1);
        do_reset("after_bad");

        run("imem_to", 32'h00500093, 10, 0, 1'b0, -1);
        do_reset("after_imem_to");
        run("imem_ack4", 32'h00500093, TO - 1, 0, 1'b0, -1);

        run("dmem_to", 32'h00002083, 0, 9, 1'b0, -1);
        do_reset("after_dmem_to");
        run("dmem_ack4", 32'h00002083, 0, TO - 1, 1'b0, -1);

        run("sw_rst", 32'h00102023, 0, 3, 1'b0, 4);
        run("addi_post", 32'h00500093, 0, 0, 1'b0, -1);
        check("addi_post retired", retired, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/core_seq_ctrl.md
CORE_SEQ_CTRL -- requirements
Module: core_seq_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum wait cycles for imem_ack/dmem_ack before trapping (range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, a synchronous, active-low reset.
REQ-004 SHALL have port instr, input, 32, the instruction word returned by instruction memory; valid when imem_ack=1.
REQ-005 SHALL have ports imem_req (output, 1) and imem_ack (input, 1), the fetch handshake.
REQ-006 SHALL have ports dmem_req (output, 1), dmem_we (output, 1) and dmem_ack (input, 1), the data-memory handshake.
REQ-007 SHALL have port br_taken, input, 1, the branch comparison result from the ALU, sampled in EXEC.
REQ-008 SHALL have outputs ir_we (1), pc_we (1), pc_sel (2: 00 = pc+4, 01 = pc+imm, 10 = rs1+imm), imm_sel (3: 0 = I, 1 = S, 2 = B, 3 = U, 4 = J), alu_src_imm (1), alu_op (2: 00 = add, 01 = sub/compare, 10 = funct-decoded) and rf_we (1).
REQ-009 SHALL have output wb_sel, 2 (00 = ALU, 01 = memory, 10 = pc+4, 11 = immediate).
REQ-010 SHALL have outputs illegal (1, sticky trap flag), retired (32, retired-instruction count) and state (3, current FSM state).

Function
REQ-011 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5.
REQ-012 FETCH SHALL hold imem_req=1 until imem_ack=1; on that cycle ir_we pulses for one cycle (latching instr into an internal IR) and the state moves to DECODE.
REQ-013 DECODE SHALL take one cycle: it decodes IR[6:0] and drives imm_sel combinationally from the IR from DECODE through WB.
REQ-014 Supported opcodes SHALL be 0110011 (R), 0010011 (I-ALU), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH), 1101111 (JAL), 1100111 (JALR), 0110111 (LUI) and 0010111 (AUIPC); any other opcode SHALL transition DECODE to TRAP.
REQ-015 EXEC SHALL take one cycle: LOAD/STORE go to MEM; BRANCH goes to FETCH with pc_we=1 and pc_sel=01 if br_taken, else 00; all other opcodes go to WB.
REQ-016 MEM SHALL hold dmem_req=1 (dmem_we=1 for STORE) until dmem_ack; STORE then returns to FETCH with pc_we=1 and pc_sel=00; LOAD goes to WB.
REQ-017 WB SHALL pulse rf_we=1 and pc_we=1 for one cycle, then return to FETCH: pc_sel=01 for JAL, 10 for JALR, 00 otherwise.
REQ-018 wb_sel SHALL be 01 for LOAD, 10 for JAL/JALR, 11 for LUI and 00 otherwise.
REQ-019 alu_src_imm SHALL be 0 for R and BRANCH and 1 otherwise; alu_op SHALL be 10 for R/I-ALU, 01 for BRANCH and 00 otherwise.
REQ-020 retired SHALL increment by 1 on each cycle where pc_we=1, wrapping from 0xFFFFFFFF to 0.
REQ-021 If a wait counter in FETCH or MEM reaches MEM_TIMEOUT without an ack, the FSM SHALL enter TRAP; an ack arriving on the timeout cycle itself SHALL win.
REQ-022 TRAP SHALL set illegal=1 and hold all strobes and requests at 0 until reset.
REQ-023 imem_ack while not in FETCH and dmem_ack while not in MEM SHALL be ignored.

Reset
REQ-024 When rst_n=0 at a clock edge, the block SHALL set state=FETCH, IR=0, the wait counter=0, retired=0 and illegal=0, with all requests and strobes at 0 on the following cycle.
REQ-025 A reset asserted mid-handshake SHALL abandon the handshake; imem_req SHALL reassert in the first cycle after rst_n returns to 1.

Structure
REQ-026 State encodings, opcode constants, and the pc_sel/imm_sel/wb_sel/alu_op encodings SHALL reside in the shared package core_pkg.
REQ-027 The opcode decode table SHALL be a combinational sub-module seq_decode (IR in; class, imm_sel, wb_sel, alu controls and illegal out).

Verification
REQ-028 Bench SHALL cover: instr=0x00500093 (addi) with imem_ack after 1 cycle -> states 0,1,2,4,0; rf_we=1, wb_sel=00, imm_sel=0 in WB; retired=1.
REQ-029 Bench SHALL cover: a lw with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, wb_sel=01, rf_we single pulse.
REQ-030 Bench SHALL cover: a beq with br_taken=1, then with br_taken=0 -> pc_sel=01, then 00; rf_we never asserts; retired += 2.
REQ-031 Bench SHALL cover: instr=0xFFFFFFFF -> TRAP after DECODE, illegal=1, no further imem_req until reset.
REQ-032 Bench SHALL cover: MEM_TIMEOUT=4 with imem_ack never asserted -> TRAP after 4 FETCH cycles; a repeat with ack on cycle 4 -> DECODE.
REQ-033 Bench SHALL cover: rst_n=0 during MEM of a sw -> next cycle state=0, dmem_req=0, retired=0, illegal=0.
